if_stage: RTL



---
 rtl/if_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage feeding the IF/ID pipeline register
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   combined_stall     global stall; IF/ID outputs hold their values
//   branch_taken       redirect request from EX (wins over stall)
//   branch_target      redirect PC; bits [1:0] are ignored
//   imem_req/addr      fetch request and word-aligned address
//   imem_ready         request accepted this cycle when imem_req is high
//   imem_rvalid/rdata  instruction response for the outstanding request
//   IF_ID_PC           PC of the presented instruction
//   IF_ID_Instruction  presented instruction (NOP after reset)
//   IF_ID_enable_out   IF/ID contents valid

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        combined_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_enable_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic        kill;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;

  logic [31:0] target_aligned;
  logic        rsp_take;

  assign target_aligned = branch_target & ~32'h0000_0003;

  // A response that is consumed straight into IF/ID lets the next request
  // go out in the same cycle, keeping a zero-wait memory at one per clock.
  always_comb begin
    rsp_take  = (state == S_WAIT) && imem_rvalid && !kill &&
                !combined_stall && !branch_taken;
    imem_req  = (state == S_REQ) || rsp_take;
    imem_addr = pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_REQ;
      pc                <= RESET_PC;
      fetch_pc          <= RESET_PC;
      kill              <= 1'b0;
      buf_pc            <= 32'h0;
      buf_instr         <= NOP;
      IF_ID_PC          <= 32'h0;
      IF_ID_Instruction <= NOP;
      IF_ID_enable_out  <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (branch_taken) begin
            pc               <= target_aligned;
            IF_ID_enable_out <= 1'b0;
            // The old-path request was accepted anyway; its response must be
            // dropped so only one request is ever outstanding.
            if (imem_ready) begin
              kill  <= 1'b1;
              state <= S_WAIT;
            end
          end else if (imem_ready) begin
            fetch_pc <= pc;
            pc       <= pc + 32'd4;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem_rvalid && kill) begin
            kill  <= 1'b0;
            state <= S_REQ;
            if (branch_taken) begin
              pc               <= target_aligned;
              IF_ID_enable_out <= 1'b0;
            end
          end else if (imem_rvalid) begin
            if (branch_taken) begin
              pc               <= target_aligned;
              IF_ID_enable_out <= 1'b0;
              state            <= S_REQ;
            end else if (combined_stall) begin
              buf_pc    <= fetch_pc;
              buf_instr <= imem_rdata;
              state     <= S_HOLD;
            end else begin
              IF_ID_PC          <= fetch_pc;
              IF_ID_Instruction <= imem_rdata;
              IF_ID_enable_out  <= 1'b1;
              if (imem_ready) begin
                fetch_pc <= pc;
                pc       <= pc + 32'd4;
              end else begin
                state <= S_REQ;
              end
            end
          end else if (branch_taken) begin
            // Request still in flight: remember to discard its response.
            pc               <= target_aligned;
            IF_ID_enable_out <= 1'b0;
            kill             <= 1'b1;
          end
        end

        S_HOLD: begin
          if (branch_taken) begin
            pc               <= target_aligned;
            IF_ID_enable_out <= 1'b0;
            state            <= S_REQ;
          end else if (!combined_stall) begin
            IF_ID_PC          <= buf_pc;
            IF_ID_Instruction <= buf_instr;
            IF_ID_enable_out  <= 1'b1;
            state             <= S_REQ;
          end
        end

        default: state <= S_REQ;
      endcase
    end
  end

endmodule
